// File: rtl/lab2q_cpu_jtag_debug_cmd_sysclk.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | lab2q_cpu_jtag_debug_cmd_sysclk                                          |
// | Captures virtual-JTAG IR/DR updates into the system clock as commands.   |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module lab2q_cpu_jtag_debug_cmd_sysclk #(
    parameter int SR_WIDTH    = 38,
    parameter int IR_WIDTH    = 2,
    parameter int SYNC_STAGES = 2,
    parameter int ACT_BIT     = 34,
    parameter int CNT_WIDTH   = 8
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [IR_WIDTH-1:0]  ir_in,
    input  logic [SR_WIDTH-1:0]  sr,
    input  logic                 vs_uir,
    input  logic                 vs_udr,
    input  logic                 cmd_ready,
    input  logic                 overrun_clr,
    output logic [SR_WIDTH-1:0]  jdo,
    output logic [IR_WIDTH-1:0]  ir_q,
    output logic                 cmd_valid,
    output logic [IR_WIDTH-1:0]  cmd_code,
    output logic                 cmd_action,
    output logic                 overrun,
    output logic [CNT_WIDTH-1:0] cmd_count
);

    localparam logic [CNT_WIDTH-1:0] C_CNT_MAX = '1;

    logic [SYNC_STAGES-1:0] udr_sync_q, udr_sync_d;
    logic [SYNC_STAGES-1:0] uir_sync_q, uir_sync_d;
    logic                   udr_hist_q, udr_hist_d;
    logic                   uir_hist_q, uir_hist_d;
    logic [SR_WIDTH-1:0]    jdo_q, jdo_d;
    logic [IR_WIDTH-1:0]    ir_d, ir_reg_q;
    logic                   cmd_valid_q, cmd_valid_d;
    logic [IR_WIDTH-1:0]    cmd_code_q, cmd_code_d;
    logic                   cmd_action_q, cmd_action_d;
    logic                   overrun_q, overrun_d;
    logic [CNT_WIDTH-1:0]   cmd_count_q, cmd_count_d;

    logic udr_edge, uir_edge, load, xfer, drop;

    always_comb begin
        udr_sync_d = {udr_sync_q[SYNC_STAGES-2:0], vs_udr};
        uir_sync_d = {uir_sync_q[SYNC_STAGES-2:0], vs_uir};
        udr_hist_d = udr_sync_q[SYNC_STAGES-1];
        uir_hist_d = uir_sync_q[SYNC_STAGES-1];

        udr_edge = udr_sync_q[SYNC_STAGES-1] & ~udr_hist_q;
        uir_edge = uir_sync_q[SYNC_STAGES-1] & ~uir_hist_q;

        xfer = cmd_valid_q & cmd_ready;
        load = udr_edge & (~cmd_valid_q | cmd_ready);
        drop = udr_edge & cmd_valid_q & ~cmd_ready;

        // ir_d already carries the bypass when IR and DR updates coincide
        ir_d         = uir_edge ? ir_in : ir_reg_q;
        jdo_d        = load ? sr : jdo_q;
        cmd_code_d   = load ? ir_d : cmd_code_q;
        cmd_action_d = load ? sr[ACT_BIT] : cmd_action_q;

        cmd_valid_d = cmd_valid_q;
        if (load) begin
            cmd_valid_d = 1'b1;
        end else if (xfer) begin
            cmd_valid_d = 1'b0;
        end

        overrun_d = overrun_q;
        if (drop) begin
            overrun_d = 1'b1;
        end else if (overrun_clr) begin
            overrun_d = 1'b0;
        end

        cmd_count_d = cmd_count_q;
        if (xfer && (cmd_count_q != C_CNT_MAX)) begin
            cmd_count_d = cmd_count_q + CNT_WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            udr_sync_q   <= '0;
            uir_sync_q   <= '0;
            udr_hist_q   <= 1'b0;
            uir_hist_q   <= 1'b0;
            jdo_q        <= '0;
            ir_reg_q     <= '0;
            cmd_valid_q  <= 1'b0;
            cmd_code_q   <= '0;
            cmd_action_q <= 1'b0;
            overrun_q    <= 1'b0;
            cmd_count_q  <= '0;
        end else begin
            udr_sync_q   <= udr_sync_d;
            uir_sync_q   <= uir_sync_d;
            udr_hist_q   <= udr_hist_d;
            uir_hist_q   <= uir_hist_d;
            jdo_q        <= jdo_d;
            ir_reg_q     <= ir_d;
            cmd_valid_q  <= cmd_valid_d;
            cmd_code_q   <= cmd_code_d;
            cmd_action_q <= cmd_action_d;
            overrun_q    <= overrun_d;
            cmd_count_q  <= cmd_count_d;
        end
    end

    assign jdo        = jdo_q;
    assign ir_q       = ir_reg_q;
    assign cmd_valid  = cmd_valid_q;
    assign cmd_code   = cmd_code_q;
    assign cmd_action = cmd_action_q;
    assign overrun    = overrun_q;
    assign cmd_count  = cmd_count_q;

endmodule
`default_nettype wire

// File: tb/tb_lab2q_cpu_jtag_debug_cmd_sysclk.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_lab2q_cpu_jtag_debug_cmd_sysclk                                       |
// | Directed stimulus with a queued scoreboard checked on each transfer.     |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_lab2q_cpu_jtag_debug_cmd_sysclk;

    localparam int SR_W  = 38;
    localparam int IR_W  = 2;
    localparam int CNT_W = 2;

    typedef struct packed {
        logic [IR_W-1:0] code;
        logic            act;
        logic [SR_W-1:0] data;
    } exp_t;

    logic             clk = 1'b0;
    logic             reset_n;
    logic [IR_W-1:0]  ir_in;
    logic [SR_W-1:0]  sr;
    logic             vs_uir, vs_udr, cmd_ready, overrun_clr;
    logic [SR_W-1:0]  jdo;
    logic [IR_W-1:0]  ir_q;
    logic             cmd_valid;
    logic [IR_W-1:0]  cmd_code;
    logic             cmd_action;
    logic             overrun;
    logic [CNT_W-1:0] cmd_count;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   exp_count = 0;

    lab2q_cpu_jtag_debug_cmd_sysclk #(
        .SR_WIDTH(SR_W), .IR_WIDTH(IR_W), .SYNC_STAGES(2), .ACT_BIT(34), .CNT_WIDTH(CNT_W)
    ) dut (
        .clk(clk), .reset_n(reset_n), .ir_in(ir_in), .sr(sr),
        .vs_uir(vs_uir), .vs_udr(vs_udr), .cmd_ready(cmd_ready), .overrun_clr(overrun_clr),
        .jdo(jdo), .ir_q(ir_q), .cmd_valid(cmd_valid), .cmd_code(cmd_code),
        .cmd_action(cmd_action), .overrun(overrun), .cmd_count(cmd_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_cmd(input logic [IR_W-1:0] code, input logic [SR_W-1:0] data);
        exp_t e;
        e.code = code;
        e.act  = data[34];
        e.data = data;
        sb.push_back(e);
    endtask

    // Level pulse long enough for the synchroniser, then low long enough to re-arm
    task automatic udr_pulse();
        vs_udr = 1'b1;
        repeat (3) tick();
        vs_udr = 1'b0;
        repeat (4) tick();
    endtask

    task automatic drain();
        cmd_ready = 1'b1;
        tick();
        cmd_ready = 1'b0;
    endtask

    // Monitor: every transfer pops the oldest expected command
    always @(negedge clk) begin
        if (reset_n === 1'b1 && cmd_valid === 1'b1 && cmd_ready === 1'b1) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_unexpected: transfer with jdo %0h but no command expected", jdo);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("sb_code", 64'(cmd_code), 64'(e.code));
                chk("sb_action", 64'(cmd_action), 64'(e.act));
                chk("sb_jdo", 64'(jdo), 64'(e.data));
            end
            chk("sb_count_pre", 64'(cmd_count), 64'(exp_count));
            if (exp_count != 3) exp_count++;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
        $fatal(1);
    end

    initial begin
        reset_n = 1'b0; ir_in = '0; sr = '0; vs_uir = 1'b0; vs_udr = 1'b0;
        cmd_ready = 1'b0; overrun_clr = 1'b0;
        repeat (3) tick();
        chk("rst_jdo", 64'(jdo), 64'd0);
        chk("rst_valid", 64'(cmd_valid), 64'd0);
        chk("rst_ir", 64'(ir_q), 64'd0);
        chk("rst_count", 64'(cmd_count), 64'd0);
        chk("rst_overrun", 64'(overrun), 64'd0);
        reset_n = 1'b1;
        tick();

        // Basic command with latency check
        ir_in = 2'b01; vs_uir = 1'b1;
        repeat (3) tick();
        vs_uir = 1'b0;
        repeat (3) tick();
        chk("ir_load", 64'(ir_q), 64'd1);
        sr = 38'h2_0000_0ABC;
        push_cmd(2'b01, sr);
        vs_udr = 1'b1;
        tick();
        tick();
        chk("lat_not_yet", 64'(cmd_valid), 64'd0);
        tick();
        chk("basic_valid", 64'(cmd_valid), 64'd1);
        chk("basic_code", 64'(cmd_code), 64'd1);
        chk("basic_action", 64'(cmd_action), 64'd0);
        chk("basic_jdo", 64'(jdo), 64'(38'h2_0000_0ABC));
        chk("basic_count", 64'(cmd_count), 64'd0);
        vs_udr = 1'b0;

        // Hold for five cycles, then transfer
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("hold_valid", 64'(cmd_valid), 64'd1);
            chk("hold_jdo", 64'(jdo), 64'(38'h2_0000_0ABC));
        end
        drain();
        chk("xfer_valid", 64'(cmd_valid), 64'd0);
        chk("xfer_count", 64'(cmd_count), 64'd1);
        repeat (3) tick();

        // Overrun: second update dropped while a command is pending
        sr = 38'h0_0000_0111;
        push_cmd(2'b01, sr);
        udr_pulse();
        chk("ovr_pending", 64'(cmd_valid), 64'd1);
        sr = 38'h4_0000_0222;
        udr_pulse();
        chk("ovr_flag", 64'(overrun), 64'd1);
        chk("ovr_jdo", 64'(jdo), 64'(38'h0_0000_0111));
        chk("ovr_action", 64'(cmd_action), 64'd0);
        overrun_clr = 1'b1;
        tick();
        overrun_clr = 1'b0;
        chk("ovr_clr", 64'(overrun), 64'd0);
        drain();
        chk("ovr_count", 64'(cmd_count), 64'd2);

        // Back-to-back: new update lands on the transfer cycle
        ir_in = 2'b10; vs_uir = 1'b1;
        sr = 38'h0_0000_0AAA;
        push_cmd(2'b10, sr);
        vs_udr = 1'b1;
        repeat (3) tick();
        chk("bypass_code", 64'(cmd_code), 64'd2);
        vs_udr = 1'b0; vs_uir = 1'b0;
        repeat (4) tick();
        sr = 38'h4_0000_0BBB;
        push_cmd(2'b10, sr);
        vs_udr = 1'b1;
        tick();
        tick();
        cmd_ready = 1'b1;
        tick();
        cmd_ready = 1'b0;
        chk("b2b_valid", 64'(cmd_valid), 64'd1);
        chk("b2b_jdo", 64'(jdo), 64'(38'h4_0000_0BBB));
        chk("b2b_action", 64'(cmd_action), 64'd1);
        chk("b2b_count", 64'(cmd_count), 64'd3);
        vs_udr = 1'b0;
        repeat (4) tick();
        drain();
        chk("sat_hold", 64'(cmd_count), 64'd3);

        // Fresh reset, then five transfers into a 2-bit counter
        reset_n = 1'b0;
        tick();
        sb.delete();
        exp_count = 0;
        reset_n = 1'b1;
        tick();
        for (int i = 0; i < 5; i++) begin
            sr = 38'h1_0000_0000 | 38'(i);
            push_cmd(2'b00, sr);
            udr_pulse();
            drain();
        end
        chk("sat_count", 64'(cmd_count), 64'd3);

        // Reset with a command pending and overrun set
        ir_in = 2'b11; vs_uir = 1'b1;
        repeat (3) tick();
        vs_uir = 1'b0;
        repeat (3) tick();
        sr = 38'h0_0000_0555;
        push_cmd(2'b11, sr);
        udr_pulse();
        udr_pulse();
        chk("pre_rst_valid", 64'(cmd_valid), 64'd1);
        chk("pre_rst_overrun", 64'(overrun), 64'd1);
        reset_n = 1'b0; vs_udr = 1'b1;
        tick();
        sb.delete();
        exp_count = 0;
        chk("rst2_jdo", 64'(jdo), 64'd0);
        chk("rst2_ir", 64'(ir_q), 64'd0);
        chk("rst2_valid", 64'(cmd_valid), 64'd0);
        chk("rst2_code", 64'(cmd_code), 64'd0);
        chk("rst2_action", 64'(cmd_action), 64'd0);
        chk("rst2_overrun", 64'(overrun), 64'd0);
        chk("rst2_count", 64'(cmd_count), 64'd0);
        tick();
        sr = 38'h4_0000_0777;
        push_cmd(2'b00, sr);
        reset_n = 1'b1;
        tick();
        tick();
        chk("rel_not_yet", 64'(cmd_valid), 64'd0);
        tick();
        chk("rel_valid", 64'(cmd_valid), 64'd1);
        chk("rel_jdo", 64'(jdo), 64'(38'h4_0000_0777));
        repeat (3) tick();
        drain();
        repeat (6) tick();
        chk("rel_single", 64'(cmd_valid), 64'd0);
        chk("rel_count", 64'(cmd_count), 64'd1);
        vs_udr = 1'b0;
        repeat (4) tick();
        chk("sb_empty", 64'(sb.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
